relu_maxpool2: RTL and testbench
================================

Name: relu_maxpool2

Overview:
- Streaming ReLU plus 2x2/stride-2 max-pool stage placed directly downstream of the second convolution layer (depthwise + pointwise).
- Consumes the 9 signed pointwise feature-map channels in raster order, one pixel per valid cycle.
- Emits 9 pooled, ReLU-clipped channels to the flatten/fully-connected stage.
- Default 8x8 input maps (12x12 with 5x5 kernel, no padding) give 4x4 output maps, 16 output beats per frame.

Parameters:
- WIDTH, 8, input feature-map columns; must be even and >= 2.
- HEIGHT, 8, input feature-map rows; must be even and >= 2.
- DATA_BITS, 15, signed width of each input and output sample.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- valid_in  input  1  all nine conv inputs carry one pixel this cycle.
- conv1_in..conv9_in  input  DATA_BITS each, signed  channel 1..9 sample.
- pool1_out..pool9_out  output  DATA_BITS each, signed  pooled, ReLU'd channel 1..9.
- pool_valid_out  output  1  one-cycle pulse; pool outputs valid.
- frame_done  output  1  one-cycle pulse with the last pooled beat of a frame.

Behaviour:
- Reset: all outputs 0; col/row counters 0; hold and line-buffer registers 0. Reset asserted mid-frame aborts the frame. The next valid_in after release is pixel (0,0).
- No backpressure. valid_in may deassert for any number of cycles. While valid_in=0, counters and storage hold.
- col counts 0..WIDTH-1 on each valid_in. At WIDTH-1 it wraps to 0 and row increments. At row=HEIGHT-1 and col=WIDTH-1, row wraps to 0, so back-to-back frames need no gap.
- Per channel c, on a valid_in cycle (x = conv input):
  - even row, even col: hold[c] <= x.
  - even row, odd col: lbuf[c][col>>1] <= max(hold[c], x). Line buffer depth is WIDTH/2.
  - odd row, even col: hold[c] <= max(lbuf[c][col>>1], x).
  - odd row, odd col: pool_out[c] <= relu(max(hold[c], x)), and pool_valid_out <= 1.
- max is a signed DATA_BITS comparison; ties select either operand (same value).
- relu(v) = 0 if v[MSB]=1, else v. No width growth, no saturation.
- Latency: outputs and pool_valid_out register on the clock edge that accepts the odd-row/odd-col pixel and are visible the following cycle.
- pool_valid_out is high for exactly one cycle per 2x2 window: (WIDTH/2)*(HEIGHT/2) pulses per frame. It is low otherwise.
- pool*_out hold their last value when pool_valid_out=0.
- frame_done pulses together with pool_valid_out for window (HEIGHT/2-1, WIDTH/2-1).
- Output order: raster over the pooled map, row-major.
- Channels are fully independent. All nine share the counters and the valid logic.
- Storage: 9 hold registers plus 9 x WIDTH/2 line-buffer entries, all DATA_BITS wide, implemented as flops.

Test Plan:
- Ramp: ch1 pixel(r,c) = 8r+c, 64 contiguous valid cycles → 16 pulses. Values: 9,11,13,15,25,…,63. Pulse k appears one cycle after input index 8*(2*(k/4)+1)+2*(k%4)+1. frame_done only with value 63.
- All-negative: every channel = -5 (15'h7FFB) → all 16 outputs = 0, pool_valid_out still pulses 16 times.
- Mixed sign window: pixels (0,0)=-3, (0,1)=7, (1,0)=-100, (1,1)=2 on ch5 → first pool5_out = 7. The same window all of -16384, -1, -2, -3 → 0. Verify channel independence with distinct data on ch1..ch9.
- Gapped input: insert random 0–3 idle cycles between ramp pixels → identical output sequence and values to the contiguous test. No pulses during gaps.
- Back-to-back frames: two ramp frames with no gap, the second offset by +100 → 32 pulses. The second frame's first output = 109. Two frame_done pulses.
- Reset mid-frame: assert rst_n=0 after 37 pixels → all outputs and pool_valid_out go 0 asynchronously. After release, a full ramp frame yields exactly the first test's results.

Source files
------------

// File: rtl/relu_maxpool2_if.sv
// relu_maxpool2_if
//   Bundles the streaming pixel input and the pooled output of the
//   ReLU + 2x2 max-pool stage.
//
//   Handshake: valid-only stream, no ready. A pixel transfers on every rising
//   clk edge where valid_in=1, and the consumer must always accept it. On the
//   output side, pool*_out and frame_done are meaningful only in the cycle
//   where pool_valid_out=1. pool_valid_out is a one-cycle pulse, and the
//   downstream stage must take the beat in that cycle.
//
//   Signals
//     valid_in              : conv1_in..conv9_in carry one pixel this cycle
//     conv1_in..conv9_in    : signed channel samples, raster order
//     pool1_out..pool9_out  : pooled, ReLU-clipped channel samples
//     pool_valid_out        : one-cycle pulse, pool outputs valid
//     frame_done            : pulses with the last pooled beat of a frame
//
//   Modports: master = pixel producer / result consumer, slave = the stage.
interface relu_maxpool2_if #(
  parameter int DATA_BITS = 15
);
  logic                        valid_in;
  logic signed [DATA_BITS-1:0] conv1_in, conv2_in, conv3_in, conv4_in, conv5_in,
                               conv6_in, conv7_in, conv8_in, conv9_in;
  logic signed [DATA_BITS-1:0] pool1_out, pool2_out, pool3_out, pool4_out, pool5_out,
                               pool6_out, pool7_out, pool8_out, pool9_out;
  logic                        pool_valid_out;
  logic                        frame_done;

  modport master (
    output valid_in,
    output conv1_in, conv2_in, conv3_in, conv4_in, conv5_in,
           conv6_in, conv7_in, conv8_in, conv9_in,
    input  pool1_out, pool2_out, pool3_out, pool4_out, pool5_out,
           pool6_out, pool7_out, pool8_out, pool9_out,
    input  pool_valid_out, frame_done
  );

  modport slave (
    input  valid_in,
    input  conv1_in, conv2_in, conv3_in, conv4_in, conv5_in,
           conv6_in, conv7_in, conv8_in, conv9_in,
    output pool1_out, pool2_out, pool3_out, pool4_out, pool5_out,
           pool6_out, pool7_out, pool8_out, pool9_out,
    output pool_valid_out, frame_done
  );
endinterface

// File: rtl/relu_maxpool2.sv
// relu_maxpool2
//   Streaming ReLU + 2x2/stride-2 max-pool over 9 independent signed channels.
//   Pixels arrive in raster order, one per valid cycle. Even rows build
//   horizontal pair maxima into a half-width line buffer. Odd rows combine
//   each pair with the buffered value and emit one pooled beat per 2x2 window.
//
//   Ports
//     clk   : rising-edge clock
//     rst_n : asynchronous active-low reset (aborts any frame in progress)
//     bus   : relu_maxpool2_if.slave (pixel stream in, pooled beats out)
module relu_maxpool2 #(
  parameter int WIDTH     = 8,
  parameter int HEIGHT    = 8,
  parameter int DATA_BITS = 15
) (
  input  logic           clk,
  input  logic           rst_n,
  relu_maxpool2_if.slave bus
);
  localparam int NCH  = 9;
  localparam int HALF = WIDTH / 2;
  localparam int CW   = (WIDTH  > 2) ? $clog2(WIDTH)  : 1;
  localparam int RW   = (HEIGHT > 2) ? $clog2(HEIGHT) : 1;
  localparam int LBW  = (HALF   > 1) ? $clog2(HALF)   : 1;

  typedef logic signed [DATA_BITS-1:0] sample_t;

  function automatic sample_t smax(input sample_t a, input sample_t b);
    return (a > b) ? a : b;
  endfunction

  function automatic sample_t relu(input sample_t v);
    return v[DATA_BITS-1] ? '0 : v;
  endfunction

  sample_t x [NCH];
  assign x[0] = bus.conv1_in;
  assign x[1] = bus.conv2_in;
  assign x[2] = bus.conv3_in;
  assign x[3] = bus.conv4_in;
  assign x[4] = bus.conv5_in;
  assign x[5] = bus.conv6_in;
  assign x[6] = bus.conv7_in;
  assign x[7] = bus.conv8_in;
  assign x[8] = bus.conv9_in;

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  sample_t       hold_q [NCH];
  sample_t       hold_d [NCH];
  sample_t       lbuf_q [NCH][HALF];
  sample_t       lbuf_d [NCH][HALF];
  sample_t       pool_q [NCH];
  sample_t       pool_d [NCH];
  logic          pvalid_q, pvalid_d;
  logic          fdone_q, fdone_d;

  logic           col_last, row_last;
  logic [LBW-1:0] lidx;

  assign col_last = (col_q == CW'(WIDTH - 1));
  assign row_last = (row_q == RW'(HEIGHT - 1));
  // One line-buffer slot per horizontal pair of input columns.
  assign lidx     = LBW'(col_q >> 1);

  always_comb begin
    col_d    = col_q;
    row_d    = row_q;
    hold_d   = hold_q;
    lbuf_d   = lbuf_q;
    pool_d   = pool_q;
    pvalid_d = 1'b0;
    fdone_d  = 1'b0;
    if (bus.valid_in) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
      // Row/column parity picks the role of the incoming pixel in its window.
      for (int c = 0; c < NCH; c++) begin
        case ({row_q[0], col_q[0]})
          2'b00:   hold_d[c]       = x[c];
          2'b01:   lbuf_d[c][lidx] = smax(hold_q[c], x[c]);
          2'b10:   hold_d[c]       = smax(lbuf_q[c][lidx], x[c]);
          default: pool_d[c]       = relu(smax(hold_q[c], x[c]));
        endcase
      end
      pvalid_d = row_q[0] & col_q[0];
      fdone_d  = row_q[0] & col_q[0] & row_last & col_last;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q    <= '0;
      row_q    <= '0;
      pvalid_q <= 1'b0;
      fdone_q  <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        hold_q[c] <= '0;
        pool_q[c] <= '0;
        for (int i = 0; i < HALF; i++) lbuf_q[c][i] <= '0;
      end
    end else begin
      col_q    <= col_d;
      row_q    <= row_d;
      pvalid_q <= pvalid_d;
      fdone_q  <= fdone_d;
      hold_q   <= hold_d;
      lbuf_q   <= lbuf_d;
      pool_q   <= pool_d;
    end
  end

  assign bus.pool1_out      = pool_q[0];
  assign bus.pool2_out      = pool_q[1];
  assign bus.pool3_out      = pool_q[2];
  assign bus.pool4_out      = pool_q[3];
  assign bus.pool5_out      = pool_q[4];
  assign bus.pool6_out      = pool_q[5];
  assign bus.pool7_out      = pool_q[6];
  assign bus.pool8_out      = pool_q[7];
  assign bus.pool9_out      = pool_q[8];
  assign bus.pool_valid_out = pvalid_q;
  assign bus.frame_done     = fdone_q;
endmodule

// File: tb/tb_relu_maxpool2.sv
// tb_relu_maxpool2
//   Self-checking bench for relu_maxpool2 (8x8 maps, 15-bit samples).
//   The reference model holds each frame as a plain 2D image per channel. When
//   the bottom-right pixel of a 2x2 window is driven, the model takes the max of
//   the four image pixels, clips it at zero, and queues the result together
//   with the cycle in which the beat must appear.
module tb_relu_maxpool2;
  localparam int W   = 8;
  localparam int H   = 8;
  localparam int DB  = 15;
  localparam int NCH = 9;
  localparam int EW  = NCH * DB + 1;

  typedef logic signed [DB-1:0] smp_t;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  relu_maxpool2_if #(.DATA_BITS(DB)) bus ();

  relu_maxpool2 #(.WIDTH(W), .HEIGHT(H), .DATA_BITS(DB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- scoreboard state ----------------
  smp_t          img [NCH][H][W];
  smp_t          cur [NCH];
  logic [EW-1:0] exp_q[$];
  int            exp_cyc_q[$];
  logic [EW-1:0] last_out = '0;
  int            n_cmp = 0;
  int            n_bad = 0;

  function automatic logic [EW-1:0] actual();
    return {bus.frame_done, bus.pool9_out, bus.pool8_out, bus.pool7_out,
            bus.pool6_out, bus.pool5_out, bus.pool4_out, bus.pool3_out,
            bus.pool2_out, bus.pool1_out};
  endfunction

  task automatic check_vec(input string name, input logic [EW-1:0] act,
                           input logic [EW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [EW-1:0] model_window(input int r, input int c);
    logic [EW-1:0] e;
    smp_t          m;
    e = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      m = img[ch][r][c];
      for (int dr = 0; dr < 2; dr++)
        for (int dc = 0; dc < 2; dc++)
          if (img[ch][r-dr][c-dc] > m) m = img[ch][r-dr][c-dc];
      if (m < 0) m = '0;
      e[ch*DB +: DB] = m;
    end
    e[EW-1] = (r == H - 1) && (c == W - 1);
    return e;
  endfunction

  function automatic smp_t rnd();
    case ($urandom_range(0, 7))
      0:       return smp_t'(15'h4000);   // most negative
      1:       return smp_t'(15'h3FFF);   // most positive
      2:       return smp_t'(0);
      3:       return smp_t'(-1);
      default: return smp_t'($urandom);
    endcase
  endfunction

  // mode 0: ch1 ramp (+offset), others random; 1: all -5;
  // 2/3: ch5 first window directed, others random; 4: fully random
  task automatic fill(input int mode, input int offset);
    for (int ch = 0; ch < NCH; ch++)
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++)
          case (mode)
            0:       img[ch][r][c] = (ch == 0) ? smp_t'(r * W + c + offset) : rnd();
            1:       img[ch][r][c] = smp_t'(-5);
            default: img[ch][r][c] = rnd();
          endcase
    if (mode == 2) begin
      img[4][0][0] = smp_t'(-3);   img[4][0][1] = smp_t'(7);
      img[4][1][0] = smp_t'(-100); img[4][1][1] = smp_t'(2);
    end
    if (mode == 3) begin
      img[4][0][0] = smp_t'(-16384); img[4][0][1] = smp_t'(-1);
      img[4][1][0] = smp_t'(-2);     img[4][1][1] = smp_t'(-3);
    end
  endtask

  // ---------------- driver ----------------
  task automatic apply_inputs();
    bus.conv1_in = cur[0]; bus.conv2_in = cur[1]; bus.conv3_in = cur[2];
    bus.conv4_in = cur[3]; bus.conv5_in = cur[4]; bus.conv6_in = cur[5];
    bus.conv7_in = cur[6]; bus.conv8_in = cur[7]; bus.conv9_in = cur[8];
  endtask

  task automatic send_pixel(input int r, input int c);
    for (int ch = 0; ch < NCH; ch++) cur[ch] = img[ch][r][c];
    apply_inputs();
    bus.valid_in = 1'b1;
    @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
    if ((r % 2 == 1) && (c % 2 == 1)) begin
      exp_q.push_back(model_window(r, c));
      exp_cyc_q.push_back(cyc);   // beat must be visible in this cycle
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_frame(input int mode, input int offset, input int gap_max,
                           input int pixels);
    fill(mode, offset);
    for (int idx = 0; idx < pixels; idx++) begin
      send_pixel(idx / W, idx % W);
      if (gap_max > 0) idle($urandom_range(0, gap_max));
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rst_n) begin
      if (exp_q.size() > 0 && exp_cyc_q[0] <= cyc) begin
        check_bit("pool_valid_pulse", bus.pool_valid_out, 1'b1);
        check_bit("pulse_on_time", 1'b1, exp_cyc_q[0] == cyc);
        e = exp_q.pop_front();
        void'(exp_cyc_q.pop_front());
        check_vec("pooled_beat", actual(), e);
        last_out = {1'b0, e[EW-2:0]};
      end else begin
        check_bit("no_spurious_pulse", bus.pool_valid_out, 1'b0);
        check_vec("hold_outputs", actual(), last_out);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.valid_in = 1'b0;
    for (int ch = 0; ch < NCH; ch++) cur[ch] = '0;
    apply_inputs();

    rst_n = 1'b0;
    idle(3);
    check_vec("reset_outputs", actual(), '0);
    check_bit("reset_pool_valid", bus.pool_valid_out, 1'b0);
    rst_n = 1'b1;
    idle(2);

    run_frame(0, 0, 0, W * H);     // contiguous ramp
    run_frame(1, 0, 0, W * H);     // all negative
    run_frame(2, 0, 0, W * H);     // mixed-sign window on ch5
    run_frame(3, 0, 0, W * H);     // all-negative window on ch5
    idle(2);
    run_frame(0, 0, 3, W * H);     // gapped ramp
    idle(3);
    run_frame(0, 0, 0, W * H);     // back-to-back ramp frames
    run_frame(0, 100, 0, W * H);
    idle(3);

    // abort a frame after 37 pixels
    run_frame(4, 0, 0, 37);
    idle(1);
    rst_n = 1'b0;
    #2;
    check_vec("async_reset_outputs", actual(), '0);
    check_bit("async_reset_pool_valid", bus.pool_valid_out, 1'b0);
    exp_q.delete();
    exp_cyc_q.delete();
    last_out = '0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
    run_frame(0, 0, 0, W * H);     // restart from pixel (0,0)
    run_frame(4, 0, 2, W * H);     // random data with gaps
    idle(5);

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d beats outstanding expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
